fifo_access_controller: RTL and testbench
=========================================

// Module: fifo_access_controller
// PURPOSE
//  Single-clock sequencer and arbiter for one fifo instance: shares the push side between
//  NUM_REQUESTERS capture sources (round-robin) and serves one pop consumer.
//  Generates fifo push/pop strobes (one-cycle pulses; they drive push_clock/pop_clock), never
//  concurrent, and a guaranteed low cycle between them. Tracks occupancy, sequences fifo clear.
// PARAMETERS
//  NUM_REQUESTERS  4   number of push requesters (2..8)
//  DATA_WIDTH      32  data word width; must match fifo DATA_WIDTH
//  FIFO_SIZE       8   fifo depth; must match fifo FIFO_SIZE
//  FLUSH_CYCLES    2   cycles fifo_clear is held high after reset or flush (>=1)
// PORTS
//  clock           in   1                      system clock, rising edge
//  clear           in   1                      async active-high reset
//  flush           in   1                      sync request: empty fifo (taken in S_IDLE only)
//  req_valid       in   NUM_REQUESTERS         per-requester push request (level)
//  req_data        in   NUM_REQUESTERS*DW      packed push data; requester i at [i*DW +: DW]
//  req_ready       out  NUM_REQUESTERS         one-hot one-cycle accept pulse
//  pop_request     in   1                      consumer pop request (level)
//  pop_valid       out  1                      one-cycle pulse: pop_data valid
//  pop_data        out  DATA_WIDTH             popped word, held until next pop
//  level           out  $clog2(FIFO_SIZE+1)    words stored
//  full / empty    out  1                      level==FIFO_SIZE / level==0
//  fifo_enable     out  1                      to fifo enable
//  fifo_clear      out  1                      to fifo clear
//  fifo_push       out  1                      to fifo push_clock
//  fifo_pop        out  1                      to fifo pop_clock
//  fifo_in_data    out  DATA_WIDTH             to fifo in_data
//  fifo_out_data   in   DATA_WIDTH             from fifo out_data
//  fifo_ready      in   1                      from fifo fifo_ready
// BEHAVIOUR
//  Reset (clear=1): state S_FLUSH, flush count 0, fifo_clear=1, fifo_enable=0,
//   fifo_push=fifo_pop=0, req_ready=0, pop_valid=0, pop_data=0, fifo_in_data=0, level=0,
//   rr pointer=NUM_REQUESTERS-1 (requester 0 wins first). All outputs registered.
//  S_FLUSH: fifo_clear=1, enable=0 for FLUSH_CYCLES cycles; level<=0; then fifo_clear<=0, ->S_IDLE.
//  S_IDLE (fifo_enable=1), priority, decided on one edge:
//   1 flush=1 -> S_FLUSH (pending pop/push ignored this cycle).
//   2 fifo_ready=0 -> stay.
//   3 pop_request && !empty -> op=POP, fifo_pop<=1, ->S_STROBE.
//   4 any req_valid && !full -> winner = first valid index after rr pointer (wrapping);
//     fifo_in_data<=req_data[winner], fifo_push<=1, req_ready[winner]<=1, rr<=winner, ->S_STROBE.
//   5 else stay.
//  S_STROBE (1 cycle, strobe high): strobe<=0, req_ready<=0; PUSH: level+1; POP: level-1;
//   ->S_RECOVER.
//  S_RECOVER (1 cycle, strobes low): POP: pop_data<=fifo_out_data, pop_valid<=1 next cycle
//   (visible in the following S_IDLE cycle, 1 cycle). ->S_IDLE.
//  Op cost: 3 cycles IDLE->STROBE->RECOVER; max one push or pop per 3 cycles.
//  Pop beats push when both pending (drain first; prevents requester starvation of consumer).
//  Push and pop strobes never high together; no strobe in two consecutive cycles.
//  Full: no req_ready issued, requesters stall. Empty: pop_request held, no pop_valid.
//  Requester holds req_valid/req_data stable until req_ready seen; may drop valid after.
//  Consumer must drop pop_request on pop_valid, else another pop is issued.
//  level never exceeds FIFO_SIZE nor underflows; width-exact, no wrap.
//  clear mid-op: immediate abort, strobes forced low, re-enter S_FLUSH; in-flight word lost.
//  flush while S_STROBE/S_RECOVER: held off until S_IDLE.
// TESTING
//  T1 reset release -> fifo_clear high exactly 2 cycles, then enable=1, level=0, empty=1.
//  T2 req 0..3 valid continuously, data 0xA0+i -> accepts order 0,1,2,3,0,...; stop at level=8,
//     full=1, req_ready held low.
//  T3 push 0x11,0x22,0x33 then pop x3 -> pop_data 0x11,0x22,0x33, level 3->0, each pop_valid 1 cycle.
//  T4 pop_request and req_valid[2] same cycle, level=1 -> pop first, then push; strobes never overlap.
//  T5 pop_request while empty for 10 cycles -> no fifo_pop, no pop_valid; push then -> pop completes.
//  T6 clear asserted during S_STROBE of a push -> fifo_push low same cycle, level=0, flush replays.

Source files
------------

// File: rtl/fifo_access_controller_if.sv
// Requester and consumer handshake bundle for fifo_access_controller.
// slave: the controller side; master: the requesters/consumer side.
interface fifo_access_controller_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_SIZE      = 8
);
  localparam int unsigned LevelWidth = $clog2(FIFO_SIZE + 1);

  logic                                 flush;
  logic [NUM_REQUESTERS-1:0]            req_valid;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQUESTERS-1:0]            req_ready;
  logic                                 pop_request;
  logic                                 pop_valid;
  logic [DATA_WIDTH-1:0]                pop_data;
  logic [LevelWidth-1:0]                level;
  logic                                 full;
  logic                                 empty;

  modport master (
    output flush, req_valid, req_data, pop_request,
    input  req_ready, pop_valid, pop_data, level, full, empty
  );

  modport slave (
    input  flush, req_valid, req_data, pop_request,
    output req_ready, pop_valid, pop_data, level, full, empty
  );
endinterface

// File: rtl/fifo_access_controller.sv
// Single-clock sequencer/arbiter for one fifo: round-robin push arbitration across requesters,
// one pop consumer, non-overlapping push/pop strobes with a low cycle between them, occupancy
// tracking and clear sequencing. Every output is registered.
module fifo_access_controller #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_SIZE      = 8,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input  logic                    clock,
  input  logic                    clear,
  fifo_access_controller_if.slave bus,
  output logic                    fifo_enable,
  output logic                    fifo_clear,
  output logic                    fifo_push,
  output logic                    fifo_pop,
  output logic [DATA_WIDTH-1:0]   fifo_in_data,
  input  logic [DATA_WIDTH-1:0]   fifo_out_data,
  input  logic                    fifo_ready
);
  localparam int unsigned LevelWidth = $clog2(FIFO_SIZE + 1);
  localparam int unsigned IdxWidth   = $clog2(NUM_REQUESTERS);
  localparam int unsigned CountWidth = $clog2(FLUSH_CYCLES + 1);

  localparam logic [LevelWidth-1:0] LevelMax  = LevelWidth'(FIFO_SIZE);
  localparam logic [CountWidth-1:0] CountLast = CountWidth'(FLUSH_CYCLES - 1);
  localparam logic [IdxWidth-1:0]   RrInit    = IdxWidth'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {StFlush, StIdle, StStrobe, StRecover} state_e;

  state_e                  state_q, state_d;
  logic [CountWidth-1:0]   count_q, count_d;
  logic                    op_pop_q, op_pop_d;

  logic [IdxWidth-1:0]     rr_q, rr_d;
  logic                    fifo_enable_q, fifo_enable_d;
  logic                    fifo_clear_q, fifo_clear_d;
  logic                    fifo_push_q, fifo_push_d;
  logic                    fifo_pop_q, fifo_pop_d;
  logic [DATA_WIDTH-1:0]   fifo_in_data_q, fifo_in_data_d;
  logic [NUM_REQUESTERS-1:0] req_ready_q, req_ready_d;
  logic                    pop_valid_q, pop_valid_d;
  logic [DATA_WIDTH-1:0]   pop_data_q, pop_data_d;
  logic [LevelWidth-1:0]   level_q, level_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;

  // Unpack the requester data bus into words.
  logic [DATA_WIDTH-1:0] req_word [NUM_REQUESTERS];
  for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
    assign req_word[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester after the last winner, wrapping.
  logic                any_valid;
  logic [IdxWidth-1:0] winner;
  logic [IdxWidth-1:0] cand;
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_q;
    cand      = rr_q;
    for (int unsigned j = 1; j <= NUM_REQUESTERS; j++) begin
      cand = IdxWidth'((32'(rr_q) + j) % NUM_REQUESTERS);
      if (!any_valid && bus.req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Idle-cycle decisions in priority order: flush, fifo not ready, pop, push.
  logic in_idle, take_flush, pop_wanted, start_pop, start_push;
  assign in_idle    = (state_q == StIdle);
  assign take_flush = in_idle && bus.flush;
  assign pop_wanted = bus.pop_request && !empty_q;
  assign start_pop  = in_idle && !bus.flush && fifo_ready && pop_wanted;
  assign start_push = in_idle && !bus.flush && fifo_ready && !pop_wanted && any_valid && !full_q;

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= StFlush;
      count_q  <= '0;
      op_pop_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_pop_q <= op_pop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_pop_d = op_pop_q;
    case (state_q)
      StFlush: begin
        if (count_q == CountLast) begin
          state_d = StIdle;
        end else begin
          count_d = count_q + CountWidth'(1);
        end
      end
      StIdle: begin
        if (take_flush) begin
          state_d = StFlush;
          count_d = '0;
        end else if (start_pop || start_push) begin
          state_d  = StStrobe;
          op_pop_d = start_pop;
        end
      end
      StStrobe:  state_d = StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StFlush;
    endcase
  end

  // Next values of the registered outputs; strobes and req_ready default low so each is a pulse.
  always_comb begin
    rr_d           = rr_q;
    fifo_enable_d  = (state_d != StFlush);
    fifo_clear_d   = (state_d == StFlush);
    fifo_push_d    = 1'b0;
    fifo_pop_d     = 1'b0;
    fifo_in_data_d = fifo_in_data_q;
    req_ready_d    = '0;
    pop_valid_d    = 1'b0;
    pop_data_d     = pop_data_q;
    level_d        = level_q;
    case (state_q)
      StFlush: level_d = '0;
      StIdle: begin
        if (take_flush) begin
          level_d = '0;
        end else if (start_pop) begin
          fifo_pop_d = 1'b1;
        end else if (start_push) begin
          fifo_push_d         = 1'b1;
          fifo_in_data_d      = req_word[winner];
          req_ready_d[winner] = 1'b1;
          rr_d                = winner;
        end
      end
      StStrobe: begin
        level_d = op_pop_q ? level_q - LevelWidth'(1) : level_q + LevelWidth'(1);
      end
      StRecover: begin
        // The fifo presents the popped word by now; capture it for the consumer.
        if (op_pop_q) begin
          pop_data_d  = fifo_out_data;
          pop_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    full_d  = (level_d == LevelMax);
    empty_d = (level_d == '0);
  end

  // Output registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rr_q           <= RrInit;
      fifo_enable_q  <= 1'b0;
      fifo_clear_q   <= 1'b1;
      fifo_push_q    <= 1'b0;
      fifo_pop_q     <= 1'b0;
      fifo_in_data_q <= '0;
      req_ready_q    <= '0;
      pop_valid_q    <= 1'b0;
      pop_data_q     <= '0;
      level_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
    end else begin
      rr_q           <= rr_d;
      fifo_enable_q  <= fifo_enable_d;
      fifo_clear_q   <= fifo_clear_d;
      fifo_push_q    <= fifo_push_d;
      fifo_pop_q     <= fifo_pop_d;
      fifo_in_data_q <= fifo_in_data_d;
      req_ready_q    <= req_ready_d;
      pop_valid_q    <= pop_valid_d;
      pop_data_q     <= pop_data_d;
      level_q        <= level_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
    end
  end

  assign fifo_enable   = fifo_enable_q;
  assign fifo_clear    = fifo_clear_q;
  assign fifo_push     = fifo_push_q;
  assign fifo_pop      = fifo_pop_q;
  assign fifo_in_data  = fifo_in_data_q;
  assign bus.req_ready = req_ready_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.level     = level_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
endmodule

// File: tb/tb_fifo_access_controller.sv
module tb_fifo_access_controller;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FS = 8;
  localparam int FC = 2;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  fifo_access_controller_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .FIFO_SIZE(FS)) bus ();

  logic          fifo_enable, fifo_clear, fifo_push, fifo_pop, fifo_ready;
  logic [DW-1:0] fifo_in_data;
  logic [DW-1:0] fifo_out_data = '0;

  fifo_access_controller #(
    .NUM_REQUESTERS(N), .DATA_WIDTH(DW), .FIFO_SIZE(FS), .FLUSH_CYCLES(FC)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .bus          (bus),
    .fifo_enable  (fifo_enable),
    .fifo_clear   (fifo_clear),
    .fifo_push    (fifo_push),
    .fifo_pop     (fifo_pop),
    .fifo_in_data (fifo_in_data),
    .fifo_out_data(fifo_out_data),
    .fifo_ready   (fifo_ready)
  );

  // Environment fifo driven by the strobes.
  logic [DW-1:0] fq[$];
  always @(posedge fifo_push) begin #1; fq.push_back(fifo_in_data); end
  always @(posedge fifo_pop) begin #1; if (fq.size() > 0) fifo_out_data = fq.pop_front(); end
  always @(posedge fifo_clear) fq.delete();

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level).
  int            k = 0;
  int            elig_at = 1000000;
  int            clear_until, popv_at, ref_rr, ref_level;
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] exp_pop_data, last_pop, exp_in;
  logic [N-1:0]  exp_ready, prev_valid;
  logic [DW-1:0] prev_data [N];
  logic          prev_pop, prev_flush, prev_fready, exp_push, exp_pop;

  int            acc_log[$];
  logic [DW-1:0] pop_log[$];
  logic          got;
  int            hits;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    ref_level   = 0;
    ref_rr      = N - 1;
    clear_until = k + FC;
    elig_at     = k + FC + 1;
    popv_at     = -1;
    last_pop    = '0;
    exp_ready   = '0;
  endtask

  task automatic apply_reset();
    clear           = 1'b1;
    bus.flush       = 1'b0;
    bus.req_valid   = '0;
    bus.pop_request = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fifo_clear", fifo_clear, 1);
    chk("rst_fifo_enable", fifo_enable, 0);
    chk("rst_fifo_push", fifo_push, 0);
    chk("rst_fifo_pop", fifo_pop, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_pop_valid", bus.pop_valid, 0);
    chk("rst_pop_data", bus.pop_data, 0);
    chk("rst_in_data", fifo_in_data, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    clear = 1'b0;
    model_reset();
  endtask

  // One clock: capture the inputs the DUT will see, advance, then compare against the model.
  task automatic cycle();
    int w;
    prev_valid  = bus.req_valid;
    for (int i = 0; i < N; i++) prev_data[i] = bus.req_data[i*DW +: DW];
    prev_pop    = bus.pop_request;
    prev_flush  = bus.flush;
    prev_fready = fifo_ready;
    @(posedge clock);
    #1;
    k++;
    exp_push  = 1'b0;
    exp_pop   = 1'b0;
    exp_ready = '0;
    exp_in    = '0;
    if (k >= elig_at) begin
      if (prev_flush) begin
        ref_q.delete();
        ref_level   = 0;
        clear_until = k + FC;
        elig_at     = k + FC + 1;
      end else if (prev_fready) begin
        if (prev_pop && ref_level > 0) begin
          exp_pop      = 1'b1;
          exp_pop_data = ref_q.pop_front();
          popv_at      = k + 2;
          elig_at      = k + 3;
        end else if (prev_valid != '0 && ref_level < FS) begin
          w = -1;
          for (int j = 1; j <= N; j++)
            if (w < 0 && prev_valid[(ref_rr + j) % N]) w = (ref_rr + j) % N;
          exp_push     = 1'b1;
          exp_ready[w] = 1'b1;
          exp_in       = prev_data[w];
          ref_rr       = w;
          elig_at      = k + 3;
        end
      end
    end
    if (k == popv_at) last_pop = exp_pop_data;
    chk("fifo_push", fifo_push, exp_push);
    chk("fifo_pop", fifo_pop, exp_pop);
    chk("req_ready", bus.req_ready, exp_ready);
    if (exp_push) chk("fifo_in_data", fifo_in_data, exp_in);
    chk("fifo_clear", fifo_clear, k < clear_until);
    chk("fifo_enable", fifo_enable, !(k < clear_until));
    chk("pop_valid", bus.pop_valid, k == popv_at);
    chk("pop_data", bus.pop_data, last_pop);
    chk("level", bus.level, ref_level);
    chk("full", bus.full, ref_level == FS);
    chk("empty", bus.empty, ref_level == 0);
    if (exp_push) begin ref_q.push_back(exp_in); ref_level++; end
    if (exp_pop) ref_level--;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) acc_log.push_back(i);
    if (bus.pop_valid) pop_log.push_back(bus.pop_data);
  endtask

  task automatic wait_ready(input int idx, input string tag);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin cycle(); got = bus.req_ready[idx]; end
    chk(tag, got, 1);
  endtask

  // Consumer drops its request in the same cycle it sees pop_valid.
  task automatic wait_pop(input string tag);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin cycle(); got = bus.pop_valid; end
    bus.pop_request = 1'b0;
    chk(tag, got, 1);
  endtask

  initial begin
    clear           = 1'b1;
    bus.flush       = 1'b0;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.pop_request = 1'b0;
    fifo_ready      = 1'b1;
    apply_reset();

    // T1: clear held for FC cycles after release, then enabled and empty.
    cycle();
    chk("t1_clear_hold", fifo_clear, 1);
    cycle();
    chk("t1_clear_done", fifo_clear, 0);
    chk("t1_enable", fifo_enable, 1);
    chk("t1_empty", bus.empty, 1);

    // T2: all requesters valid, round-robin until full.
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 32'hA0 + i;
    bus.req_valid = '1;
    acc_log.delete();
    repeat (40) cycle();
    chk("t2_level_full", bus.level, FS);
    chk("t2_full", bus.full, 1);
    chk("t2_accepts", acc_log.size(), FS);
    for (int i = 0; i < FS; i++)
      chk("t2_rr_order", (i < acc_log.size()) ? acc_log[i] : -1, i % N);
    bus.req_valid = '0;
    pop_log.delete();
    bus.pop_request = 1'b1;
    repeat (30) cycle();
    bus.pop_request = 1'b0;
    chk("t2_drained", bus.level, 0);
    for (int i = 0; i < FS; i++)
      chk("t2_pop_order", (i < pop_log.size()) ? pop_log[i] : '1, 32'hA0 + (i % N));
    cycle();

    // T3: three pushes then three pops in order.
    bus.req_valid[1] = 1'b1;
    bus.req_data[1*DW +: DW] = 32'h11;
    wait_ready(1, "t3_accept_11");
    bus.req_data[1*DW +: DW] = 32'h22;
    wait_ready(1, "t3_accept_22");
    bus.req_data[1*DW +: DW] = 32'h33;
    wait_ready(1, "t3_accept_33");
    bus.req_valid = '0;
    repeat (3) cycle();
    chk("t3_level3", bus.level, 3);
    pop_log.delete();
    repeat (3) begin bus.pop_request = 1'b1; wait_pop("t3_pop"); end
    chk("t3_pop0", (pop_log.size() > 0) ? pop_log[0] : '1, 32'h11);
    chk("t3_pop1", (pop_log.size() > 1) ? pop_log[1] : '1, 32'h22);
    chk("t3_pop2", (pop_log.size() > 2) ? pop_log[2] : '1, 32'h33);
    repeat (2) cycle();
    chk("t3_level0", bus.level, 0);

    // T4: pop and push pending together at level 1; pop goes first.
    bus.req_valid[0] = 1'b1;
    bus.req_data[0*DW +: DW] = 32'h44;
    wait_ready(0, "t4_accept_44");
    bus.req_valid = '0;
    repeat (3) cycle();
    bus.pop_request  = 1'b1;
    bus.req_valid[2] = 1'b1;
    bus.req_data[2*DW +: DW] = 32'h77;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin cycle(); got = fifo_pop | fifo_push; end
    chk("t4_pop_first", fifo_pop, 1);
    chk("t4_no_overlap", fifo_push, 0);
    wait_pop("t4_pop_done");
    chk("t4_pop_data", bus.pop_data, 32'h44);
    wait_ready(2, "t4_push_after");
    bus.req_valid = '0;
    bus.pop_request = 1'b1;
    wait_pop("t4_drain");
    chk("t4_drain_data", bus.pop_data, 32'h77);
    repeat (3) cycle();

    // T5: pop request while empty is held off until a word arrives.
    bus.pop_request = 1'b1;
    hits = 0;
    repeat (10) begin cycle(); if (fifo_pop || bus.pop_valid) hits++; end
    chk("t5_no_pop_empty", hits, 0);
    bus.req_valid[0] = 1'b1;
    bus.req_data[0*DW +: DW] = 32'h55;
    wait_ready(0, "t5_accept");
    bus.req_valid = '0;
    wait_pop("t5_pop_done");
    chk("t5_pop_data", bus.pop_data, 32'h55);
    repeat (3) cycle();

    // T6: clear during a push strobe aborts it immediately.
    bus.req_valid[3] = 1'b1;
    bus.req_data[3*DW +: DW] = 32'h66;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin cycle(); got = fifo_push; end
    chk("t6_push_seen", got, 1);
    bus.req_valid = '0;
    #1;
    clear = 1'b1;
    #1;
    chk("t6_push_abort", fifo_push, 0);
    chk("t6_level", bus.level, 0);
    chk("t6_clear", fifo_clear, 1);
    chk("t6_ready_low", bus.req_ready, 0);
    apply_reset();
    cycle();
    chk("t6_replay_hold", fifo_clear, 1);
    cycle();
    chk("t6_replay_done", fifo_clear, 0);

    // Flush request from idle.
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    chk("flush_clear", fifo_clear, 1);
    repeat (3) cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 1600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (exp_ready[i]) begin
          bus.req_valid[i] = 1'($urandom_range(1));
          bus.req_data[i*DW +: DW] = $urandom();
        end else if (!bus.req_valid[i] && $urandom_range(2) == 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*DW +: DW] = $urandom();
        end
      end
      bus.pop_request = ($urandom_range(3) < (((c / 200) % 2 == 1) ? 3 : 1));
      bus.flush       = ($urandom_range(59) == 0);
      fifo_ready      = ($urandom_range(7) != 0);
      cycle();
    end
    bus.req_valid   = '0;
    bus.pop_request = 1'b0;
    bus.flush       = 1'b0;
    fifo_ready      = 1'b1;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
